cb_hdr_segmenter: RTL and testbench
===================================

// Module: cb_hdr_segmenter
// PURPOSE
//  Splits TB descriptors into code blocks and emits one 64-bit CB header per code block on a valid/ready stream.
//  Sits between the TB scheduler and the CB encoder feed.
//  Successor to the fixed single-stream CB header struct: multi-channel, with a per-channel 9-bit sequence counter
//  and automatic last_cb / remainder-length generation.
// PARAMETERS
//  NUM_CH    4      number of independent channels; CH_W = $clog2(NUM_CH) (min 1), localparam
//  HDR_TYPE  2'b01  value driven in the header_type field
//  SEQ_INIT  9'd0   per-channel sequence value after reset
// PORTS
//  clk               in   1     single clock
//  rst               in   1     synchronous, active-high reset
//  s_tb_valid        in   1     TB descriptor valid
//  s_tb_ready        out  1     descriptor accepted when valid&&ready
//  s_tb_length_bytes in   20    TB length in bytes
//  s_tb_index        in   8     TB index, copied to each header
//  s_tb_tti          in   2     TTI, copied to each header
//  s_tb_ch           in   CH_W  channel; selects the sequence counter
//  s_cb_bits         in   16    nominal CB input length in bits
//  s_out_bits        in   16    CB output code length in bits
//  m_hdr_valid       out  1     header valid
//  m_hdr_ready       in   1     downstream ready
//  m_hdr_data        out  64    [63:48] out_len, [47:32] in_len, [31:25] 0, [24:16] seq, [15:8] tb_index, [7:6] 0,
//                                [5:4] tti, [3] last_cb, [2] 0, [1:0] HDR_TYPE
//  err_drop          out  1     1-cycle pulse: descriptor dropped
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): s_tb_ready=0 while rst=1, then 1; m_hdr_valid=0, m_hdr_data=0, err_drop=0;
//    all channel seq=SEQ_INIT; FSM=IDLE. A reset mid-TB aborts the TB: no further headers for it.
//  - FSM IDLE: s_tb_ready=1.
//    On accept:
//      if length_bytes==0 or cb_bits==0: err_drop=1 the next cycle, stay IDLE;
//      else latch fields, rem = length_bytes*8 (23b, no overflow), go EMIT.
//  - FSM EMIT: s_tb_ready=0. The header is registered: the first header is valid the cycle after accept.
//    in_len = (rem <= cb_bits) ? rem[15:0] : cb_bits; last_cb = (rem <= cb_bits); seq = cnt[ch].
//  - Handshake: m_hdr_data is held stable while m_hdr_valid && !m_hdr_ready.
//    On each transfer: rem -= in_len; cnt[ch] = cnt[ch]+1 mod 512 (wraps 511->0); next header presented the
//    following cycle (back-to-back, 1 header/cycle under ready=1).
//  - After the last_cb transfer: m_hdr_valid=0, return to IDLE; s_tb_ready=1 the following cycle. m_hdr_valid never
//    depends combinationally on m_hdr_ready.
//  - Only cnt[s_tb_ch] of the active TB changes; other channels are untouched. Dropped descriptors do not advance seq.
//  - CB count = ceil(length_bytes*8/cb_bits); a short last CB carries the remainder; an exact multiple yields a full last CB.
// CONFIGURATION
//  CB_HDR_SEGMENTER_STATS_EN defined:
//    adds outputs stat_cb_cnt[31:0] (headers transferred), stat_tb_cnt[31:0] (TBs completed),
//    stat_drop_cnt[15:0] (err_drop pulses).
//    All wrap, all reset to 0, all update the cycle after the event.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. ch0, len=1000B, cb=3000, out=6000, ready=1 -> 3 headers:
//     in_len 3000/3000/2000, seq 0/1/2, last_cb 0/0/1, out_len 6000; first valid 1 cycle after accept.
//  2. len=750B, cb=3000 -> 2 headers, in_len 3000/3000, last_cb only on the 2nd; s_tb_ready=1 one cycle after the 2nd transfer.
//  3. Test 1 with m_hdr_ready=0 for 5 cycles after header 2 appears -> data stable all 5 cycles; exactly 3 headers, no duplicates.
//  4. ch2 preloaded to seq 511 via 511 single-CB TBs -> next ch2 header seq=511, following one 0;
//     ch1 TB in between still starts at seq 0.
//  5. len=0, then cb=0 -> no header, err_drop 1-cycle pulse each, seq unchanged; stats build: stat_drop_cnt=2.
//  6. rst asserted during header 2 of test 1 -> m_hdr_valid=0 the next cycle, then a new ch0 TB starts at seq 0.

Source files
------------

// File: rtl/cb_hdr_segmenter.sv
// Splits TB descriptors into code blocks and emits one registered 64-bit CB header per block.
// Optional statistics counters: define CB_HDR_SEGMENTER_STATS_EN.
module cb_hdr_segmenter #(
  parameter int          NUM_CH   = 4,
  parameter logic [1:0]  HDR_TYPE = 2'b01,
  parameter logic [8:0]  SEQ_INIT = 9'd0,
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tb_valid,
  output logic            s_tb_ready,
  input  logic [19:0]     s_tb_length_bytes,
  input  logic [7:0]      s_tb_index,
  input  logic [1:0]      s_tb_tti,
  input  logic [CH_W-1:0] s_tb_ch,
  input  logic [15:0]     s_cb_bits,
  input  logic [15:0]     s_out_bits,
  output logic            m_hdr_valid,
  input  logic            m_hdr_ready,
  output logic [63:0]     m_hdr_data,
  output logic            err_drop
`ifdef CB_HDR_SEGMENTER_STATS_EN
  ,
  output logic [31:0]     stat_cb_cnt,
  output logic [31:0]     stat_tb_cnt,
  output logic [15:0]     stat_drop_cnt
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]      state;
  logic [22:0]     rem_q;
  logic [15:0]     cb_q;
  logic [15:0]     out_q;
  logic [7:0]      idx_q;
  logic [1:0]      tti_q;
  logic [CH_W-1:0] ch_q;
  logic [8:0]      seq_cnt [NUM_CH];

  logic            xfer;
  logic            bad_desc;
  logic [22:0]     tb_bits;
  logic [22:0]     rem_nxt;
  logic [8:0]      seq_nxt;

  // Builds a header from the remaining bit count; the final block carries whatever is left.
  function automatic logic [63:0] build_hdr(input logic [22:0] rem, input logic [15:0] cb,
                                            input logic [15:0] outb, input logic [8:0] seq,
                                            input logic [7:0] idx, input logic [1:0] tti);
    logic        last;
    logic [15:0] in_len;
    last   = (rem <= {7'd0, cb});
    in_len = last ? rem[15:0] : cb;
    return {outb, in_len, 7'd0, seq, idx, 2'b00, tti, last, 1'b0, HDR_TYPE};
  endfunction

  assign s_tb_ready = !rst && (state == ST_IDLE);
  assign xfer       = m_hdr_valid && m_hdr_ready;
  assign bad_desc   = (s_tb_length_bytes == 20'd0) || (s_cb_bits == 16'd0);
  assign tb_bits    = {s_tb_length_bytes, 3'b000};
  assign rem_nxt    = rem_q - {7'd0, m_hdr_data[47:32]};
  assign seq_nxt    = seq_cnt[ch_q] + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      m_hdr_valid <= 1'b0;
      m_hdr_data  <= '0;
      err_drop    <= 1'b0;
      rem_q       <= '0;
      cb_q        <= '0;
      out_q       <= '0;
      idx_q       <= '0;
      tti_q       <= '0;
      ch_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) seq_cnt[i] <= SEQ_INIT;
    end else begin
      err_drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_tb_valid) begin
            if (bad_desc) begin
              err_drop <= 1'b1;
            end else begin
              rem_q       <= tb_bits;
              cb_q        <= s_cb_bits;
              out_q       <= s_out_bits;
              idx_q       <= s_tb_index;
              tti_q       <= s_tb_tti;
              ch_q        <= s_tb_ch;
              m_hdr_data  <= build_hdr(tb_bits, s_cb_bits, s_out_bits, seq_cnt[s_tb_ch],
                                       s_tb_index, s_tb_tti);
              m_hdr_valid <= 1'b1;
              state       <= ST_EMIT;
            end
          end
        end
        default: begin
          if (xfer) begin
            seq_cnt[ch_q] <= seq_nxt;
            if (m_hdr_data[3]) begin
              m_hdr_valid <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              rem_q      <= rem_nxt;
              m_hdr_data <= build_hdr(rem_nxt, cb_q, out_q, seq_nxt, idx_q, tti_q);
            end
          end
        end
      endcase
    end
  end

`ifdef CB_HDR_SEGMENTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cb_cnt   <= '0;
      stat_tb_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (xfer) stat_cb_cnt <= stat_cb_cnt + 32'd1;
      if (xfer && m_hdr_data[3]) stat_tb_cnt <= stat_tb_cnt + 32'd1;
      if (err_drop) stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cb_hdr_segmenter.sv
// Randomized and directed bench for cb_hdr_segmenter against a queue-based header model.
module tb_cb_hdr_segmenter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tb_valid = 1'b0;
  logic        s_tb_ready;
  logic [19:0] s_tb_length_bytes = '0;
  logic [7:0]  s_tb_index = '0;
  logic [1:0]  s_tb_tti = '0;
  logic [1:0]  s_tb_ch = '0;
  logic [15:0] s_cb_bits = '0;
  logic [15:0] s_out_bits = '0;
  logic        m_hdr_valid;
  logic        m_hdr_ready = 1'b1;
  logic [63:0] m_hdr_data;
  logic        err_drop;
`ifdef CB_HDR_SEGMENTER_STATS_EN
  logic [31:0] stat_cb_cnt;
  logic [31:0] stat_tb_cnt;
  logic [15:0] stat_drop_cnt;
`endif

  cb_hdr_segmenter dut (
    .clk(clk), .rst(rst),
    .s_tb_valid(s_tb_valid), .s_tb_ready(s_tb_ready),
    .s_tb_length_bytes(s_tb_length_bytes), .s_tb_index(s_tb_index),
    .s_tb_tti(s_tb_tti), .s_tb_ch(s_tb_ch),
    .s_cb_bits(s_cb_bits), .s_out_bits(s_out_bits),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_hdr_data(m_hdr_data), .err_drop(err_drop)
`ifdef CB_HDR_SEGMENTER_STATS_EN
    , .stat_cb_cnt(stat_cb_cnt), .stat_tb_cnt(stat_tb_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          drop_cyc = -10;
  int          last_cyc = -10;
  logic [63:0] exp_q [$];
  int          seq_m [4];
  int          cbs_m = 0;
  int          tbs_m = 0;
  int          drops_m = 0;
  bit          rdy_rand = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: every descriptor expands to ceil(bits/cb) headers, last one holding the remainder.
  task automatic model_accept(input int len, input int cb, input int outb,
                              input int idx, input int tti, input int ch);
    int          bits, n, inl, seq;
    logic [63:0] h;
    if (len == 0 || cb == 0) begin
      drop_cyc = cyc + 1;
      drops_m++;
      return;
    end
    bits = len * 8;
    n = (bits + cb - 1) / cb;
    for (int k = 0; k < n; k++) begin
      inl = (k == n - 1) ? bits - (n - 1) * cb : cb;
      seq = (seq_m[ch] + k) % 512;
      h = {outb[15:0], inl[15:0], 7'd0, seq[8:0], idx[7:0], 2'b00, tti[1:0],
           (k == n - 1), 1'b0, 2'b01};
      exp_q.push_back(h);
    end
    seq_m[ch] = (seq_m[ch] + n) % 512;
    cbs_m += n;
    tbs_m++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) seq_m[i] = 0;
    cbs_m = 0; tbs_m = 0; drops_m = 0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk); #1;
    if (rdy_rand) m_hdr_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: compares every transfer, hold stability, drop pulses and ready turnaround.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("err_drop", {63'd0, err_drop}, {63'd0, (cyc == drop_cyc)});
      if (cyc == last_cyc + 1) chk("ready_after_last", {63'd0, s_tb_ready}, 64'd1);
      if (m_hdr_valid) begin
        chk("ready_while_emit", {63'd0, s_tb_ready}, 64'd0);
        if (prev_stall) chk("hold_stable", m_hdr_data, prev_data);
        if (m_hdr_ready) begin
          if (exp_q.size() == 0) chk("extra_hdr", m_hdr_data, 64'd0);
          else chk("hdr", m_hdr_data, exp_q.pop_front());
          if (m_hdr_data[3]) last_cyc = cyc;
        end
      end
      prev_stall = m_hdr_valid && !m_hdr_ready;
      prev_data  = m_hdr_data;
    end
  end

  task automatic send_tb(input int len, input int cb, input int outb,
                         input int idx, input int tti, input int ch);
    int t = 0;
    @(posedge clk); #1;
    s_tb_valid = 1'b1;
    s_tb_length_bytes = len[19:0];
    s_cb_bits = cb[15:0];
    s_out_bits = outb[15:0];
    s_tb_index = idx[7:0];
    s_tb_tti = tti[1:0];
    s_tb_ch = ch[1:0];
    @(negedge clk);
    while (!s_tb_ready && t < 3000) begin @(negedge clk); t++; end
    if (!s_tb_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      s_tb_valid = 1'b0;
      return;
    end
    model_accept(len, cb, outb, idx, tti, ch);
    @(posedge clk); #1;
    s_tb_valid = 1'b0;
    @(negedge clk);
    chk("first_vld", {63'd0, m_hdr_valid}, {63'd0, (len != 0 && cb != 0)});
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_hdr_valid) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) chk("drain_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] held;
    int len, cb;
    model_reset();
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, s_tb_ready}, 64'd0);
    chk("rst_valid", {63'd0, m_hdr_valid}, 64'd0);
    chk("rst_data", m_hdr_data, 64'd0);
    chk("rst_drop", {63'd0, err_drop}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, s_tb_ready}, 64'd1);

    // Three CBs with remainder, then two exact CBs
    send_tb(1000, 3000, 6000, 8'h11, 1, 0);
    drain();
    send_tb(750, 3000, 6000, 8'h22, 2, 0);
    drain();

    // Five-cycle stall on header 2
    m_hdr_ready = 1'b0;
    send_tb(1000, 3000, 6000, 8'h33, 3, 0);
    @(posedge clk); #1 m_hdr_ready = 1'b1;
    @(posedge clk); #1 m_hdr_ready = 1'b0;
    @(negedge clk);
    held = m_hdr_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", m_hdr_data, held);
      chk("stall_vld", {63'd0, m_hdr_valid}, 64'd1);
    end
    @(posedge clk); #1 m_hdr_ready = 1'b1;
    drain();

    // Drops: zero length, zero cb
    send_tb(0, 3000, 6000, 8'h44, 0, 0);
    send_tb(100, 0, 6000, 8'h45, 0, 0);
    repeat (2) @(negedge clk);
    send_tb(10, 3000, 6000, 8'h46, 0, 0);
    drain();
`ifdef CB_HDR_SEGMENTER_STATS_EN
    chk("stat_drop", {48'd0, stat_drop_cnt}, 64'd2);
`endif

    // Reset in the middle of header 2
    m_hdr_ready = 1'b0;
    send_tb(1000, 3000, 6000, 8'h55, 0, 0);
    @(posedge clk); #1 m_hdr_ready = 1'b1;
    @(posedge clk); #1 m_hdr_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_ready", {63'd0, s_tb_ready}, 64'd0);
    @(posedge clk); #1 rst = 1'b0; m_hdr_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {63'd0, m_hdr_valid}, 64'd0);
    chk("midrst_rdy1", {63'd0, s_tb_ready}, 64'd1);
    send_tb(1000, 3000, 6000, 8'h66, 0, 0);
    drain();

    // Sequence wrap on ch2, with ch1 interleaved
    for (int i = 0; i < 511; i++) send_tb(1, 8, 16, i & 255, i & 3, 2);
    drain();
    send_tb(1000, 3000, 6000, 8'h77, 1, 1);
    drain();
    send_tb(2, 8, 16, 8'h78, 2, 2);
    drain();

    // Randomized traffic with random backpressure
    rdy_rand = 1;
    send_tb(20'hFFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 3, 3);
    for (int i = 0; i < 150; i++) begin
      len = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 2000);
      cb  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(256, 16000);
      send_tb(len, cb, $urandom_range(0, 65535), $urandom_range(0, 255),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
    drain();
    rdy_rand = 0;
    @(posedge clk); #1 m_hdr_ready = 1'b1;
    repeat (2) @(negedge clk);
`ifdef CB_HDR_SEGMENTER_STATS_EN
    chk("stat_cb", {32'd0, stat_cb_cnt}, cbs_m);
    chk("stat_tb", {32'd0, stat_tb_cnt}, tbs_m);
    chk("stat_drop_all", {48'd0, stat_drop_cnt}, drops_m);
`endif
    chk("queue_empty", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
